// File: rtl/demux4_stream.sv
// Registered 1-to-4 stream demultiplexer with per-channel one-entry holding registers.
// Words go to one channel chosen by in_dest, or to all four at once in broadcast mode.
module demux4_stream #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_dest,
  input  logic             in_bcast,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready
);

  localparam int unsigned NCH = 4;
  localparam logic EMPTY = 1'b0;
  localparam logic FULL  = 1'b1;

  logic [NCH-1:0]   state;
  logic [NCH-1:0]   state_nxt;
  logic [WIDTH-1:0] data     [NCH];
  logic [WIDTH-1:0] data_nxt [NCH];
  logic [NCH-1:0]   sel;
  logic [NCH-1:0]   can_accept;
  logic             accept;

  // A channel can take a word if it is empty or being drained this cycle.
  always_comb begin
    sel        = '0;
    can_accept = '0;
    for (int k = 0; k < int'(NCH); k++) begin
      sel[k]        = in_bcast | (in_dest == 2'(k));
      can_accept[k] = (state[k] == EMPTY) | out_ready[k];
    end
  end

  // Broadcast needs every channel free so it is delivered all-or-nothing.
  assign in_ready = in_bcast ? (&can_accept) : can_accept[in_dest];
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_nxt = state;
    data_nxt  = data;
    for (int k = 0; k < int'(NCH); k++) begin
      if (accept && sel[k]) begin
        state_nxt[k] = FULL;
        data_nxt[k]  = in_data;
      end else if ((state[k] == FULL) && out_ready[k]) begin
        state_nxt[k] = EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= {NCH{EMPTY}};
      for (int k = 0; k < int'(NCH); k++) data[k] <= '0;
    end else begin
      state <= state_nxt;
      for (int k = 0; k < int'(NCH); k++) data[k] <= data_nxt[k];
    end
  end

  always_comb begin
    for (int k = 0; k < int'(NCH); k++) out_valid[k] = (state[k] == FULL);
  end

  assign out_data0 = data[0];
  assign out_data1 = data[1];
  assign out_data2 = data[2];
  assign out_data3 = data[3];

endmodule

// File: tb/tb_demux4_stream.sv
// Bench for demux4_stream: directed steps followed by a randomized soak
// checked against per-channel queues of expected words.
module tb_demux4_stream;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] in_data;
  logic [1:0] in_dest;
  logic       in_bcast;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data0, out_data1, out_data2, out_data3;
  logic [3:0] out_valid;
  logic [3:0] out_ready;

  int checks = 0;
  int failures = 0;

  logic [7:0] q [4][$];

  demux4_stream #(.WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_data(in_data), .in_dest(in_dest), .in_bcast(in_bcast),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data0(out_data0), .out_data1(out_data1),
    .out_data2(out_data2), .out_data3(out_data3),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] odata(input int k);
    case (k)
      0: return out_data0;
      1: return out_data1;
      2: return out_data2;
      default: return out_data3;
    endcase
  endfunction

  task automatic drive(input logic v, input logic b, input logic [1:0] d,
                       input logic [7:0] x, input logic [3:0] r);
    in_valid = v; in_bcast = b; in_dest = d; in_data = x; out_ready = r;
    #1;
  endtask

  // Advance through one rising edge and return at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 8'h00, 4'b0000);
    @(negedge clk);
    check("reset_valid", 32'(out_valid), 32'h0);
    check("reset_data", {out_data3, out_data2, out_data1, out_data0}, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single route to channel 2, then drain it.
    drive(1'b1, 1'b0, 2'd2, 8'hA5, 4'b0000);
    check("route_ready", 32'(in_ready), 32'h1);
    tick();
    drive(1'b0, 1'b0, 2'd2, 8'hA5, 4'b0000);
    check("route_valid", 32'(out_valid), 32'b0100);
    check("route_data2", 32'(out_data2), 32'hA5);
    drive(1'b0, 1'b0, 2'd2, 8'hA5, 4'b0100);
    tick();
    check("route_drain", 32'(out_valid), 32'b0000);

    // Backpressure on channel 1 must not block channel 3.
    drive(1'b1, 1'b0, 2'd1, 8'h11, 4'b0000);
    tick();
    drive(1'b1, 1'b0, 2'd1, 8'h22, 4'b0000);
    check("bp_ready_ch1", 32'(in_ready), 32'h0);
    tick();
    check("bp_hold_ch1", 32'(out_data1), 32'h11);
    check("bp_valid_hold", 32'(out_valid), 32'b0010);
    drive(1'b1, 1'b0, 2'd3, 8'h22, 4'b0000);
    check("bp_ready_ch3", 32'(in_ready), 32'h1);
    tick();
    drive(1'b0, 1'b0, 2'd0, 8'h00, 4'b0000);
    check("bp_data3", 32'(out_data3), 32'h22);
    check("bp_valid", 32'(out_valid), 32'b1010);
    drive(1'b0, 1'b0, 2'd0, 8'h00, 4'b1111);
    tick();
    check("bp_drain", 32'(out_valid), 32'b0000);

    // Simultaneous pop and push on channel 0, sustained at full rate.
    drive(1'b1, 1'b0, 2'd0, 8'h01, 4'b0000);
    tick();
    drive(1'b1, 1'b0, 2'd0, 8'h02, 4'b0001);
    check("pp_ready", 32'(in_ready), 32'h1);
    tick();
    check("pp_data", {out_valid, out_data0}, {4'b0001, 8'h02});
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 2'd0, 8'(8'h10 + i), 4'b0001);
      check($sformatf("pp_stream_ready%0d", i), 32'(in_ready), 32'h1);
      tick();
      check($sformatf("pp_stream%0d", i), {out_valid, out_data0}, {4'b0001, 8'(8'h10 + i)});
    end
    drive(1'b0, 1'b0, 2'd0, 8'h00, 4'b0001);
    tick();
    check("pp_drain", 32'(out_valid), 32'b0000);

    // Broadcast waits for all channels, then lands everywhere at once.
    drive(1'b1, 1'b0, 2'd2, 8'h33, 4'b0000);
    tick();
    drive(1'b1, 1'b1, 2'd0, 8'h5A, 4'b0000);
    check("bc_blocked", 32'(in_ready), 32'h0);
    tick();
    check("bc_nochange", {out_valid, out_data2}, {4'b0100, 8'h33});
    drive(1'b1, 1'b1, 2'd0, 8'h5A, 4'b0100);
    check("bc_ready", 32'(in_ready), 32'h1);
    tick();
    drive(1'b0, 1'b0, 2'd0, 8'h00, 4'b0000);
    check("bc_valid", 32'(out_valid), 32'b1111);
    check("bc_data", {out_data3, out_data2, out_data1, out_data0}, 32'h5A5A5A5A);

    // Asynchronous reset mid-cycle with all channels full.
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'h0);
    check("async_rst_data", {out_data3, out_data2, out_data1, out_data0}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("post_rst_valid", 32'(out_valid), 32'h0);

    // Random soak against per-channel queues of expected words.
    for (int c = 0; c < 10000; c++) begin
      logic [3:0] can;
      logic       exp_rdy;
      logic [3:0] exp_vld;
      logic       v, b;
      logic [1:0] d;
      logic [7:0] x;
      logic [3:0] r;
      v = ($urandom_range(0, 9) < 7);
      b = ($urandom_range(0, 9) < 2);
      d = 2'($urandom_range(0, 3));
      x = 8'($urandom);
      r = 4'($urandom);
      drive(v, b, d, x, r);
      for (int k = 0; k < 4; k++) begin
        exp_vld[k] = (q[k].size() != 0);
        can[k] = (q[k].size() == 0) || r[k];
      end
      exp_rdy = b ? (&can) : can[d];
      check("soak_ready", 32'(in_ready), 32'(exp_rdy));
      check("soak_valid", 32'(out_valid), 32'(exp_vld));
      for (int k = 0; k < 4; k++) begin
        if (exp_vld[k] && r[k]) begin
          check($sformatf("soak_data%0d", k), 32'(odata(k)), 32'(q[k][0]));
          void'(q[k].pop_front());
        end
      end
      if (v && exp_rdy) begin
        for (int k = 0; k < 4; k++) if (b || (d == 2'(k))) q[k].push_back(x);
      end
      tick();
    end

    // Drain what remains and confirm nothing was lost or duplicated.
    drive(1'b0, 1'b0, 2'd0, 8'h00, 4'b1111);
    for (int k = 0; k < 4; k++) begin
      if (q[k].size() != 0) begin
        check($sformatf("final_data%0d", k), 32'(odata(k)), 32'(q[k][0]));
        void'(q[k].pop_front());
      end
    end
    tick();
    check("final_empty", 32'(out_valid), 32'h0);
    check("final_queues", 32'(q[0].size() + q[1].size() + q[2].size() + q[3].size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
